mips_cpu_lsu: RTL

Load/store unit between the CPU datapath and the Avalon-style memory bus that feeds `mips_cpu_ram`. It accepts one byte/half/word load or store per request, performs the alignment check, and issues a word-aligned bus transaction with the correct big-endian byte lanes. It honours `waitrequest` with a timeout counter, then returns sign/zero-extended load data or a store completion on a single-cycle response strobe.

---
 rtl/mips_cpu_lsu.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu: load/store unit between the CPU datapath and the
// Avalon-style memory bus. Big-endian lanes: byteenable[3] is byte offset 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | req_ready high; request latched and alignment-checked on accept
// S_BUS  | read/write strobe held on the bus until waitrequest drops or times out
// S_DATA | readdata valid; lane extracted and extended
// S_RESP | single-cycle resp_valid strobe, then back to S_IDLE
module mips_cpu_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;
  // Abort fires on the waitrequest cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] address_d, writedata_d, resp_data_d;
  logic [3:0]  byteenable_d;
  logic        read_d, write_d, resp_err_d;

  logic        req_misaligned;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ld_data;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);

  // Alignment / reserved-size check on the incoming request.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: req_misaligned = 1'b0;
      SZ_HALF: req_misaligned = req_addr[0];
      SZ_WORD: req_misaligned = (req_addr[1:0] != 2'b00);
      SZ_RSVD: req_misaligned = 1'b1;
      default: req_misaligned = 1'b1;
    endcase
  end

  // Store lane replication and byte enables for the incoming request.
  always_comb begin
    st_data = req_wdata;
    st_be   = 4'b1111;
    case (req_size)
      SZ_BYTE: begin
        st_data = {4{req_wdata[7:0]}};
        st_be   = 4'b1000 >> req_addr[1:0];
      end
      SZ_HALF: begin
        st_data = {2{req_wdata[15:0]}};
        st_be   = req_addr[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        st_data = req_wdata;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Load lane extraction from the latched offset, then sign/zero extension.
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = readdata[31:24];
      2'd1:    lane_byte = readdata[23:16];
      2'd2:    lane_byte = readdata[15:8];
      default: lane_byte = readdata[7:0];
    endcase
    lane_half = off_q[1] ? readdata[15:0] : readdata[31:16];
    case (size_q)
      SZ_BYTE: ld_data = {{24{~uns_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: ld_data = {{16{~uns_q & lane_half[15]}}, lane_half};
      default: ld_data = readdata;
    endcase
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wait_cnt_d   = wait_cnt_q;
    address_d    = address;
    writedata_d  = writedata;
    byteenable_d = byteenable;
    read_d       = read;
    write_d      = write;
    resp_data_d  = resp_data;
    resp_err_d   = resp_err;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          uns_d  = req_unsigned;
          off_d  = req_addr[1:0];
          if (req_misaligned) begin
            state_d     = S_RESP;
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end else begin
            state_d      = S_BUS;
            wait_cnt_d   = '0;
            address_d    = {req_addr[31:2], 2'b00};
            read_d       = ~req_write;
            write_d      = req_write;
            writedata_d  = req_write ? st_data : '0;
            byteenable_d = req_write ? st_be : 4'b1111;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read) begin
            state_d = S_DATA;
          end else begin
            state_d     = S_RESP;
            resp_data_d = '0;
            resp_err_d  = 1'b0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            read_d      = 1'b0;
            write_d     = 1'b0;
            state_d     = S_RESP;
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end
        end
      end
      S_DATA: begin
        state_d     = S_RESP;
        resp_data_d = ld_data;
        resp_err_d  = 1'b0;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      wait_cnt_q <= '0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      wait_cnt_q <= wait_cnt_d;
      address    <= address_d;
      writedata  <= writedata_d;
      byteenable <= byteenable_d;
      read       <= read_d;
      write      <= write_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
    end
  end

endmodule
